pll_lock_sequencer: RTL and testbench

Sequences the iCE40 SB_PLL40_CORE wrapper after configuration and on lock loss.
- Drives the PLL active-low reset (RESETB) and waits for LOCK with a timeout.
- Requires LOCK to be stable for a set time, then releases the system reset after a fixed delay.
- Retries a bounded number of times, then enters a sticky fault state.
- Runs on the PLL reference clock (16 MHz), so it never depends on the clock it controls.

---
 rtl/pll_lock_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings up the iCE40 PLL from its reference clock and gates system reset on lock.
// Optional PLL_SEQ_BYPASS_ON_FAULT_EN: on FAULT, bypass the PLL and run degraded at the reference rate.
module pll_lock_sequencer #(
    parameter int RESET_HOLD    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int LOCK_STABLE   = 256,
    parameter int RELEASE_DELAY = 16,
    parameter int MAX_RETRY     = 3
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    output logic       PLL_RESETB,
    output logic       PLL_BYPASS,
    output logic       SYS_RESETN,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);

    localparam logic [2:0] S_HOLD    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_STABLE  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

`ifdef PLL_SEQ_BYPASS_ON_FAULT_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    localparam logic [15:0] HOLD_END = 16'(RESET_HOLD - 1);
    localparam logic [15:0] TO_END   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STB_END  = 16'(LOCK_STABLE - 1);
    localparam logic [15:0] REL_END  = 16'(RELEASE_DELAY - 1);
    localparam logic [3:0]  RTY_MAX  = 4'(MAX_RETRY);

    logic        lock_m;
    logic        lock_s;
    logic [2:0]  state;
    logic [2:0]  state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [3:0]  retry_n;
    logic [7:0]  loss_n;
    logic        fail;
    logic        fault_rel;

    // Next-state decision for the sequencer; every lock test uses the synchronized lock_s.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = RETRY_CNT;
        loss_n  = LOSS_CNT;
        fail    = 1'b0;
        case (state)
            S_HOLD: begin
                if (cnt == HOLD_END) begin
                    state_n = S_WAIT;
                    cnt_n   = 16'd0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_n = S_STABLE;
                    cnt_n   = 16'd0;
                end else if (cnt == TO_END) begin
                    fail = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    fail = 1'b1;
                end else if (cnt == STB_END) begin
                    state_n = S_RELEASE;
                    cnt_n   = 16'd0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    fail = 1'b1;
                end else if (cnt == REL_END) begin
                    state_n = S_RUN;
                    cnt_n   = 16'd0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_n = S_HOLD;
                    cnt_n   = 16'd0;
                    retry_n = 4'd0;
                    if (LOSS_CNT != 8'hFF) begin
                        loss_n = LOSS_CNT + 8'd1;
                    end
                end
            end
            S_FAULT: begin
                // Counts the degraded-mode release delay, then parks.
                if (cnt != REL_END) begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: begin
                state_n = S_HOLD;
                cnt_n   = 16'd0;
            end
        endcase
        if (fail) begin
            cnt_n = 16'd0;
            if (RETRY_CNT == RTY_MAX) begin
                state_n = S_FAULT;
            end else begin
                state_n = S_HOLD;
                retry_n = RETRY_CNT + 4'd1;
            end
        end
    end

    assign fault_rel = BYP && (state == S_FAULT) && (cnt == REL_END);

    // State, counters, lock synchronizer and registered outputs decoded from the next state.
    always_ff @(posedge REFERENCECLK) begin
        if (!RESET) begin
            lock_m     <= 1'b0;
            lock_s     <= 1'b0;
            state      <= S_HOLD;
            cnt        <= 16'd0;
            PLL_RESETB <= 1'b0;
            PLL_BYPASS <= 1'b0;
            SYS_RESETN <= 1'b0;
            READY      <= 1'b0;
            FAULT      <= 1'b0;
            RETRY_CNT  <= 4'd0;
            LOSS_CNT   <= 8'd0;
        end else begin
            lock_m     <= PLL_LOCK;
            lock_s     <= lock_m;
            state      <= state_n;
            cnt        <= cnt_n;
            RETRY_CNT  <= retry_n;
            LOSS_CNT   <= loss_n;
            PLL_RESETB <= !((state_n == S_HOLD) ||
                            ((state_n == S_FAULT) && !BYP));
            PLL_BYPASS <= BYP && (state_n == S_FAULT);
            SYS_RESETN <= (state_n == S_RUN) || fault_rel;
            READY      <= (state_n == S_RUN);
            FAULT      <= (state_n == S_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed and random lock patterns against a phase/age reference model.
// Follows PLL_SEQ_BYPASS_ON_FAULT_EN when defined.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int RH = 4;
    localparam int TO = 20;
    localparam int LS = 8;
    localparam int RD = 3;
    localparam int MR = 2;

`ifdef PLL_SEQ_BYPASS_ON_FAULT_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic       PLL_RESETB;
    logic       PLL_BYPASS;
    logic       SYS_RESETN;
    logic       READY;
    logic       FAULT;
    logic [3:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;

    always #31 clk = ~clk;

    pll_lock_sequencer #(
        .RESET_HOLD   (RH),
        .LOCK_TIMEOUT (TO),
        .LOCK_STABLE  (LS),
        .RELEASE_DELAY(RD),
        .MAX_RETRY    (MR)
    ) dut (
        .REFERENCECLK(clk),
        .RESET       (rst_n),
        .PLL_LOCK    (lock),
        .PLL_RESETB  (PLL_RESETB),
        .PLL_BYPASS  (PLL_BYPASS),
        .SYS_RESETN  (SYS_RESETN),
        .READY       (READY),
        .FAULT       (FAULT),
        .RETRY_CNT   (RETRY_CNT),
        .LOSS_CNT    (LOSS_CNT)
    );

    // Reference model: current phase plus cycles spent in it.
    typedef enum int {M_HOLD, M_WAIT, M_STABLE, M_RELEASE, M_RUN, M_FAULT} phase_t;
    phase_t m_ph = M_HOLD;
    int     m_age = 0;
    int     m_retry = 0;
    int     m_loss = 0;
    bit     m_sync[$] = '{1'b0, 1'b0};

    function automatic void enter(phase_t p);
        m_ph  = p;
        m_age = 0;
    endfunction

    function automatic void model_edge(bit r, bit lk);
        bit ls;
        bit fail;
        if (!r) begin
            enter(M_HOLD);
            m_retry = 0;
            m_loss  = 0;
            m_sync  = '{1'b0, 1'b0};
            return;
        end
        ls = m_sync.pop_front();
        m_sync.push_back(lk);
        fail = 1'b0;
        case (m_ph)
            M_HOLD:
                if (m_age + 1 == RH) enter(M_WAIT);
                else m_age++;
            M_WAIT:
                if (ls) enter(M_STABLE);
                else if (m_age + 1 == TO) fail = 1'b1;
                else m_age++;
            M_STABLE:
                if (!ls) fail = 1'b1;
                else if (m_age + 1 == LS) enter(M_RELEASE);
                else m_age++;
            M_RELEASE:
                if (!ls) fail = 1'b1;
                else if (m_age + 1 == RD) enter(M_RUN);
                else m_age++;
            M_RUN:
                if (!ls) begin
                    if (m_loss < 255) m_loss++;
                    m_retry = 0;
                    enter(M_HOLD);
                end
            default:
                if (m_age < 1000) m_age++;
        endcase
        if (fail) begin
            if (m_retry == MR) enter(M_FAULT);
            else begin
                m_retry++;
                enter(M_HOLD);
            end
        end
    endfunction

    function automatic logic [16:0] model_out();
        logic rb, bp, sn, rd, ft;
        rb = !((m_ph == M_HOLD) || ((m_ph == M_FAULT) && !BYP));
        bp = BYP && (m_ph == M_FAULT);
        sn = (m_ph == M_RUN) || (BYP && (m_ph == M_FAULT) && (m_age >= RD));
        rd = (m_ph == M_RUN);
        ft = (m_ph == M_FAULT);
        return {rb, bp, sn, rd, ft, 4'(m_retry), 8'(m_loss)};
    endfunction

    function automatic logic [16:0] dut_out();
        return {PLL_RESETB, PLL_BYPASS, SYS_RESETN, READY, FAULT,
                RETRY_CNT, LOSS_CNT};
    endfunction

    task automatic cyc(input bit r, input bit lk);
        logic [16:0] got;
        logic [16:0] want;
        rst_n = r;
        lock  = lk;
        @(posedge clk);
        model_edge(r, lk);
        @(negedge clk);
        cyc_n++;
        got  = dut_out();
        want = model_out();
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL outputs cycle %0d: got %h expected %h",
                   cyc_n, got, want);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic bit cond(int sel);
        case (sel)
            0: return READY === 1'b1;
            1: return PLL_RESETB === 1'b1;
            2: return FAULT === 1'b1;
            3: return PLL_RESETB === 1'b0;
            4: return READY === 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input bit lk, input int lim,
                            output int n);
        n = 0;
        while (!cond(sel) && n < lim) begin
            cyc(1'b1, lk);
            n++;
        end
        checks++;
        assert (cond(sel)) else begin
            errors++;
            $error("FAIL wait_sel%0d: not reached after %0d cycles expected within %0d",
                   sel, n, lim);
        end
    endtask

    initial begin
        int n;

        // Reset and normal bring-up.
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("reset_vec", 32'(dut_out()), 32'd0);
        wait_for(1, 1'b0, 50, n);
        chk("hold_low", n, RH);
        repeat (9) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        wait_for(0, 1'b1, 100, n);
        chk("lock_to_ready", n, 2 + LS + RD);
        chk("retry_bringup", RETRY_CNT, 0);

        // Timeout on the first attempt, lock on the second.
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        wait_for(1, 1'b0, 50, n);
        wait_for(3, 1'b0, TO + 10, n);
        chk("timeout_len", n, TO);
        chk("retry_timeout", RETRY_CNT, 1);
        wait_for(1, 1'b0, 50, n);
        chk("hold_low_retry", n, RH);
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        wait_for(0, 1'b1, 100, n);
        chk("retry_ready", RETRY_CNT, 1);

        // Single-cycle glitch during the stability window.
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        wait_for(1, 1'b0, 50, n);
        repeat (5) cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        wait_for(3, 1'b1, 50, n);
        chk("retry_glitch", RETRY_CNT, 1);
        wait_for(1, 1'b1, 50, n);
        chk("hold_low_glitch", n, RH);
        wait_for(0, 1'b1, 100, n);

        // Lock loss in RUN, then repeated until LOSS_CNT saturates.
        cyc(1'b1, 1'b0);
        n = 1;
        while (READY === 1'b1 && n < 20) begin
            cyc(1'b1, 1'b1);
            n++;
        end
        chk("loss_latency", n, 3);
        chk("loss_cnt1", LOSS_CNT, 1);
        chk("loss_sysn", SYS_RESETN, 0);
        wait_for(0, 1'b1, 100, n);
        for (int i = 1; i < 300; i++) begin
            cyc(1'b1, 1'b0);
            wait_for(4, 1'b1, 10, n);
            wait_for(0, 1'b1, 100, n);
        end
        chk("loss_sat", LOSS_CNT, 255);

        // Reset while in the stability window.
        cyc(1'b1, 1'b0);
        wait_for(4, 1'b1, 10, n);
        wait_for(1, 1'b1, 50, n);
        repeat (4) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        chk("reset_stable", 32'(dut_out()), 32'd0);
        wait_for(1, 1'b1, 50, n);
        chk("hold_low_restart", n, RH);
        wait_for(0, 1'b1, 100, n);

        // Retry exhaustion into FAULT, then reset out of it.
        cyc(1'b0, 1'b0);
        wait_for(2, 1'b0, 400, n);
        chk("fault_retry", RETRY_CNT, MR);
        repeat (RD) cyc(1'b1, 1'b0);
        chk("fault_sysn", SYS_RESETN, BYP);
        chk("fault_bypass", PLL_BYPASS, BYP);
        chk("fault_resetb", PLL_RESETB, BYP);
        repeat (10) cyc(1'b1, 1'b1);
        chk("fault_sticky", FAULT, 1);
        chk("fault_ready", READY, 0);
        cyc(1'b0, 1'b1);
        chk("reset_fault", 32'(dut_out()), 32'd0);
        wait_for(1, 1'b1, 50, n);
        chk("hold_low_after_fault", n, RH);
        wait_for(0, 1'b1, 100, n);

        // Random lock segments with occasional resets.
        repeat (150) begin
            int len;
            bit v;
            len = $urandom_range(1, 40);
            v   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) cyc(1'b0, v);
            repeat (len) cyc(1'b1, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
